// File: rtl/hex_scan_driver.sv
// hex_scan_driver
//   Time-multiplexed driver for DIGITS common-anode seven-segment digits on a
//   shared active-low segment bus. One digit is strobed per slot of DIV
//   cycles. The first cycle of every slot is dark so that the segment pattern
//   of the previous digit never ghosts onto the next anode. The displayed value
//   is held in a shadow register. A new value is staged on load and moves into
//   the shadow only at a frame boundary, so a frame never shows a mix of old
//   and new digits.
//
// Ports
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   value      in   4*DIGITS  display value, nibble i -> digit i (digit 0 = LSD)
//   load       in   one-cycle strobe that captures value into staging
//   digit_en   in   DIGITS    per-digit enable (0 = dark), sampled live
//   blank_lz   in   1 = suppress leading zeros, sampled live
//   seg        out  7         active-low segments, seg[0]=a .. seg[6]=g
//   an         out  DIGITS    active-low one-hot anode strobe, all 1s when dark
//   frame_done out  one-cycle pulse in the cycle after the last slot of a frame
module hex_scan_driver #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [4*DIGITS-1:0]    r_stage;
    logic [4*DIGITS-1:0]    r_shadow;
    logic                   r_pending;

    logic                   w_tick;
    logic                   w_frame_wrap;
    logic [DIGITS-1:0]      w_lz;
    logic [3:0]             w_nib;
    logic                   w_en;
    logic                   w_lz_sel;
    logic                   w_dark;
    logic [DIGITS-1:0]      w_an;
    logic [6:0]             w_seg;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_tick       = (r_cnt == CNT_LAST);
    assign w_frame_wrap = w_tick && (r_idx == IDX_LAST);

    // Prescaler and digit index.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            if (w_tick) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Staging and frame-boundary commit. A load landing exactly on the wrap
    // bypasses staging so it is not delayed by a whole extra frame.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_stage   <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (load && w_frame_wrap) begin
                r_stage   <= value;
                r_shadow  <= value;
                r_pending <= 1'b0;
            end else if (load) begin
                r_stage   <= value;
                r_pending <= 1'b1;
            end else if (w_frame_wrap && r_pending) begin
                r_shadow  <= r_stage;
                r_pending <= 1'b0;
            end
        end
    end

    // w_lz[i] = shadow nibbles DIGITS-1..i are all zero.
    always_comb begin
        logic acc;
        acc  = 1'b1;
        w_lz = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc     = acc & (r_shadow[4*i +: 4] == 4'h0);
            w_lz[i] = acc;
        end
    end

    // Per-digit selects by current index.
    always_comb begin
        w_nib    = 4'h0;
        w_en     = 1'b0;
        w_lz_sel = 1'b0;
        w_an     = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib    = r_shadow[4*i +: 4];
                w_en     = digit_en[i];
                w_lz_sel = w_lz[i];
                w_an[i]  = 1'b0;
            end
        end
    end

    // Digit 0 is exempt from leading-zero blanking so zero still shows "0".
    assign w_dark = !w_en
                  || (blank_lz && (r_idx != '0) && w_lz_sel)
                  || (r_cnt == '0);

    assign w_seg = decode(w_nib);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            seg        <= 7'b1111111;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= w_dark ? 7'b1111111 : w_seg;
            an         <= w_dark ? {DIGITS{1'b1}} : w_an;
            frame_done <= w_frame_wrap;
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Testbench for hex_scan_driver with DIGITS=4, DIV=4.
// The reference model tracks the absolute cycle position since reset release
// and derives digit/phase/frame boundary arithmetically from it.
module tb_hex_scan_driver;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FR     = DIGITS * DIV;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    hex_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .Clock(Clock), .Resetn(Resetn), .value(value), .load(load),
        .digit_en(digit_en), .blank_lz(blank_lz),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 Clock = ~Clock;

    int          n_chk = 0;
    int          n_fail = 0;
    int          pos;
    logic [15:0] m_stage, m_shadow;
    bit          m_pend;
    logic [6:0]  dec [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos      = 0;
        m_stage  = 16'h0;
        m_shadow = 16'h0;
        m_pend   = 1'b0;
    endtask

    // One clock: predict outputs from the pre-edge position, advance, check.
    task automatic step(input bit ld, input logic [15:0] v);
        int         d, ph;
        bit         dark, wrap;
        logic [3:0] nib;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        load  = ld;
        value = v;
        d     = (pos / DIV) % DIGITS;
        ph    = pos % DIV;
        wrap  = (pos % FR) == FR - 1;
        nib   = 4'((m_shadow >> (4 * d)) & 16'hF);
        dark  = (ph == 0) || !digit_en[d] ||
                (blank_lz && d != 0 && (m_shadow >> (4 * d)) == 0);
        e_an  = dark ? 4'b1111 : ~(4'b0001 << d);
        e_seg = dark ? 7'b1111111 : dec[nib];
        if (ld) begin
            if (wrap) begin m_shadow = v; m_pend = 1'b0; end
            else begin m_stage = v; m_pend = 1'b1; end
        end else if (wrap && m_pend) begin
            m_shadow = m_stage;
            m_pend   = 1'b0;
        end
        @(posedge Clock);
        #1;
        pos++;
        load = 1'b0;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("frame_done", 32'(frame_done), 32'(wrap));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0);
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < FR && (pos % FR) != p; i++) step(1'b0, 16'h0);
    endtask

    initial begin
        dec = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        model_reset();

        // Reset held low.
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_fd", 32'(frame_done), 32'h0);
        end
        Resetn = 1'b1;

        // First frames with shadow=0.
        run(40);

        // Tear-free load at cycle 5 of a frame.
        run_to(5);
        step(1'b1, 16'hA3F8);
        run(40);

        // Two loads in one frame: last wins.
        run_to(2);
        step(1'b1, 16'h1111);
        run_to(9);
        step(1'b1, 16'h2222);
        run(36);

        // Load coinciding with frame wrap.
        run_to(15);
        step(1'b1, 16'h0005);
        run(20);

        // Leading-zero suppression.
        blank_lz = 1'b1;
        run_to(3);
        step(1'b1, 16'h0040);
        run(36);
        step(1'b1, 16'h0000);
        run(36);
        blank_lz = 1'b0;

        // Per-digit enable.
        step(1'b1, 16'h8421);
        run(20);
        digit_en = 4'b0101;
        run(36);
        digit_en = 4'hF;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                logic [15:0] rv;
                rv = 16'($urandom_range(0, 65535));
                if ($urandom_range(0, 1) == 0) rv = rv & 16'h00FF;
                step(1'b1, rv);
            end else begin
                step(1'b0, 16'h0);
            end
        end
        digit_en = 4'hF;
        blank_lz = 1'b0;

        // Mid-frame reset with a pending value at idx=2.
        run_to(0);
        step(1'b1, 16'h9999);
        run(20);
        run_to(1);
        step(1'b1, 16'h7777);
        run_to(9);
        #2;
        Resetn = 1'b0;
        #1;
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_an", 32'(an), 32'hF);
        chk("async_fd", 32'(frame_done), 32'h0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        model_reset();
        run(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
